store_buffer: RTL and testbench

//  FIFO of committed stores between the execute stage and the data Memory write port.
//  - Accepts one word store per cycle and drains one per cycle into port 0 of Memory.
//  - Forwards the youngest buffered matching store to same-cycle loads, so that

---
 rtl/store_buffer.sv | 90 +++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Committed-store FIFO between execute and the Memory write port, with youngest-match load forwarding.
// Optional in-place coalescing with the youngest entry is enabled by defining STORE_BUF_COALESCE_EN.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_WIDTH-1:0]      st_addr,
    input  logic [DATA_WIDTH-1:0]      st_data,
    input  logic [ADDR_WIDTH-1:0]      ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    input  logic                       drain_stall,
    output logic                       mem_write_enable,
    output logic [ADDR_WIDTH-1:0]      mem_write_addr,
    output logic [DATA_WIDTH-1:0]      mem_write_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         head, tail, wr_idx;
    logic [CW-1:0]         count_q;
    logic                  full, coalesce_match, st_accept, alloc;

    assign full             = (count_q == CW'(DEPTH));
    assign empty            = (count_q == '0);
    assign count            = count_q;
    assign mem_write_enable = !empty && !drain_stall;
    assign mem_write_addr   = addr_mem[head];
    assign mem_write_data   = data_mem[head];

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail - PW'(1);
    // A lone head that is leaving this cycle cannot absorb the store; it must allocate.
    assign coalesce_match = !empty && (addr_mem[youngest] == st_addr)
                            && !((count_q == CW'(1)) && mem_write_enable);
    assign st_ready       = !full || coalesce_match;
    assign wr_idx         = coalesce_match ? youngest : tail;
`else
    assign coalesce_match = 1'b0;
    assign st_ready       = !full;
    assign wr_idx         = tail;
`endif

    assign st_accept = st_valid && st_ready;
    assign alloc     = st_accept && !coalesce_match;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (addr_mem[head + PW'(k)] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[head + PW'(k)];
            end
        end
    end

    // NOTE: the entry array is not reset; validity comes only from head and count.
    always_ff @(posedge clk) begin
        if (st_accept) begin
            addr_mem[wr_idx] <= st_addr;
            data_mem[wr_idx] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (mem_write_enable) head <= head + PW'(1);
            if (alloc)            tail <= tail + PW'(1);
            count_q <= count_q + CW'(alloc) - CW'(mem_write_enable);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          drain_stall;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic [2:0]    count;
    logic          empty;

    store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .drain_stall(drain_stall),
        .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Model decisions taken in the current cycle, applied at the next rising edge.
    bit            p_drain, p_acc, p_coal;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Drive one cycle's inputs after the falling edge and compare every output to the model.
    task automatic drive_check(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [AW-1:0] ld, input bit stall);
        bit            e_we, e_ready, e_coal, e_hit;
        logic [DW-1:0] e_fwd;
        @(negedge clk);
        st_valid = v; st_addr = a; st_data = d; ld_addr = ld; drain_stall = stall;
        #1;
        e_we   = (q.size() > 0) && !stall;
        e_coal = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        e_coal = (q.size() > 0) && (q[q.size()-1].addr == a) && !(q.size() == 1 && e_we);
`endif
        e_ready = (q.size() < DEPTH) || e_coal;
        e_hit   = 1'b0;
        e_fwd   = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == ld) begin
                e_hit = 1'b1;
                e_fwd = q[i].data;
                break;
            end
        end
        check("st_ready", 64'(st_ready), 64'(e_ready));
        check("empty", 64'(empty), 64'(q.size() == 0));
        check("count", 64'(count), 64'(q.size()));
        check("mem_we", 64'(mem_write_enable), 64'(e_we));
        check("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        check("fwd_data", 64'(fwd_data), 64'(e_fwd));
        if (q.size() > 0) begin
            check("mem_addr", 64'(mem_write_addr), 64'(q[0].addr));
            check("mem_data", 64'(mem_write_data), 64'(q[0].data));
        end
        p_drain = e_we;
        p_acc   = v && e_ready;
        p_coal  = e_coal;
        p_addr  = a;
        p_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_acc && p_coal) q[q.size()-1].data = p_data;
        if (p_drain) void'(q.pop_front());
        if (p_acc && !p_coal) q.push_back('{addr: p_addr, data: p_data});
        p_drain = 0; p_acc = 0; p_coal = 0;
    endtask

    task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] ld, input bit stall);
        drive_check(v, a, d, ld, stall);
        tick();
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        return AW'(32'h10 + 4 * $urandom_range(0, 3));
    endfunction

    initial begin
        reset = 1'b0; st_valid = 0; st_addr = 0; st_data = 0; ld_addr = 0; drain_stall = 0;
        p_drain = 0; p_acc = 0; p_coal = 0; p_addr = 0; p_data = 0;
        #2;
        check("rst_ready", 64'(st_ready), 64'd1);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_we", 64'(mem_write_enable), 64'd0);
        check("rst_hit", 64'(fwd_hit), 64'd0);
        @(negedge clk); reset = 1'b1;

        // Two stores drain on consecutive cycles.
        cyc(1, 32'h10, 32'h11, 0, 0);
        drive_check(1, 32'h14, 32'h22, 0, 0);
        check("t1_w0", 64'(mem_write_addr), 64'h10);
        tick();
        drive_check(0, 0, 0, 0, 0);
        check("t1_w1", 64'(mem_write_data), 64'h22);
        tick();
        drive_check(0, 0, 0, 0, 0);
        check("t1_empty", 64'(empty), 64'd1);
        tick();

        // Fill under stall, fifth store held off, then release.
        for (int i = 0; i < 4; i++) cyc(1, AW'(32'h100 + 4 * i), DW'(i + 1), 0, 1);
        drive_check(1, 32'h200, 32'h55, 0, 1);
        check("t2_full_rdy", 64'(st_ready), 64'd0);
        check("t2_count", 64'(count), 64'd4);
        tick();
        drive_check(1, 32'h200, 32'h55, 0, 0);
        check("t2_drain_full_rdy", 64'(st_ready), 64'd0);
        tick();
        drain_all();
        drive_check(0, 0, 0, 0, 0);
        check("t2_ready_after", 64'(st_ready), 64'd1);
        tick();

        // Youngest match forwards.
        cyc(1, 32'h20, 32'hAA, 0, 1);
        cyc(1, 32'h20, 32'hBB, 0, 1);
        drive_check(0, 0, 0, 32'h20, 1);
        check("t3_hit", 64'(fwd_hit), 64'd1);
        check("t3_data", 64'(fwd_data), 64'hBB);
        tick();
        drive_check(0, 0, 0, 32'h24, 1);
        check("t3_miss", 64'(fwd_hit), 64'd0);
        tick();
        drain_all();

        // Enqueue and drain together at count == 1.
        cyc(1, 32'h40, 32'h1, 0, 1);
        drive_check(1, 32'h44, 32'h2, 0, 0);
        tick();
        drive_check(0, 0, 0, 0, 1);
        check("t4_count", 64'(count), 64'd1);
        check("t4_head", 64'(mem_write_addr), 64'h44);
        tick();
        drain_all();

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 3; i++) cyc(1, AW'(32'h60 + 4 * i), DW'(32'h70 + i), 0, 1);
        drive_check(0, 0, 0, 32'h60, 0);
        reset = 1'b0;
        #1;
        check("t5_we", 64'(mem_write_enable), 64'd0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_hit", 64'(fwd_hit), 64'd0);
        q.delete();
        p_drain = 0; p_acc = 0; p_coal = 0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h60, 0);

        // Same-address stores under stall.
        cyc(1, 32'h30, 32'h1, 0, 1);
        cyc(1, 32'h30, 32'h2, 0, 1);
        drive_check(0, 0, 0, 32'h30, 1);
`ifdef STORE_BUF_COALESCE_EN
        check("t6_count", 64'(count), 64'd1);
`else
        check("t6_count", 64'(count), 64'd2);
`endif
        check("t6_fwd", 64'(fwd_data), 64'h2);
        tick();
        drain_all();

        // Random traffic over a small address pool.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 6, pick_addr(), $urandom, pick_addr(),
                $urandom_range(0, 9) < 3);
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
